// File: rtl/eight_bit_cla.sv
// eight_bit_cla
//   Registered 8-bit carry-lookahead adder: {cout,sout} = a + b + cin, with signed overflow.
//   Two 4-bit lookahead groups produce group generate/propagate terms. A second-level
//   lookahead unit turns those into the carries into bit 4 and out of bit 7. Neither
//   level ripples a carry. The result is captured on the rising edge and is visible
//   one cycle after a valid input.
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  synchronous active-low reset
//   in_valid   in   1  a/b/cin valid; an add is captured on this edge
//   a, b       in   8  addends (unsigned, or two's complement for ovf)
//   cin        in   1  carry-in
//   out_valid  out  1  outputs hold the add captured on the previous edge
//   sout       out  8  sum
//   cout       out  1  carry out of bit 7
//   ovf        out  1  signed overflow
module eight_bit_cla (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic       out_valid,
  output logic [7:0] sout,
  output logic       cout,
  output logic       ovf
);

  // 4-bit lookahead group: returns {GG, GP, c3, c2, c1}. Each internal carry is
  // a flat sum of products of g/p and the group carry-in.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic c1, c2, c3, gg, gp;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp = &p;
    return {gg, gp, c3, c2, c1};
  endfunction

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [7:0] w_c;
  logic [4:0] w_grp0;
  logic [4:0] w_grp1;
  logic       w_c4;
  logic       w_c8;
  logic [7:0] w_sum;
  logic       w_ovf;

  logic       r_out_valid;
  logic [7:0] r_sout;
  logic       r_cout;
  logic       r_ovf;

  // Two-level lookahead datapath: bit g/p, group terms, second-level carries, sum.
  always_comb begin
    w_g    = a & b;
    w_p    = a ^ b;
    w_grp0 = cla4(w_g[3:0], w_p[3:0], cin);
    // The group carry-in term for group 1 cancels out of GG/GP. The internal
    // carries of group 1 are recomputed below once c4 is known.
    w_grp1 = cla4(w_g[7:4], w_p[7:4], 1'b0);
    // Second level: both carries are built only from group terms and cin.
    w_c4   = w_grp0[4] | (w_grp0[3] & cin);
    w_c8   = w_grp1[4] | (w_grp1[3] & w_grp0[4]) | (w_grp1[3] & w_grp0[3] & cin);
    w_grp1 = cla4(w_g[7:4], w_p[7:4], w_c4);
    w_c    = {w_grp1[2:0], w_c4, w_grp0[2:0], cin};
    w_sum  = w_p ^ w_c;
    // The carry into the sign bit differs from the carry out exactly on signed overflow.
    w_ovf  = w_c8 ^ w_c[7];
  end

  // Result register: reset wins over in_valid, and outputs hold while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sout      <= 8'h00;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sout <= w_sum;
        r_cout <= w_c8;
        r_ovf  <= w_ovf;
      end else begin
        r_sout <= r_sout;
        r_cout <= r_cout;
        r_ovf  <= r_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sout      = r_sout;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_eight_bit_cla.sv
// tb_eight_bit_cla
//   Scoreboard bench for eight_bit_cla. Each driven add pushes {ovf,cout,sout},
//   computed from a 9-bit reference add, onto a queue. The entry is popped and
//   compared when out_valid is expected to rise. Idle cycles check that the
//   outputs hold, and reset cycles check the zeroed outputs.
module tb_eight_bit_cla;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic [7:0] sout;
  logic       cout;
  logic       ovf;

  int         total;
  int         bad;
  logic [9:0] exp_q[$];
  logic [9:0] held;

  eight_bit_cla dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sout      (sout),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y,
                                          input logic c);
    logic [8:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y} + {8'h00, c};
    v = (x[7] == y[7]) && (s[7] != x[7]);
    return {v, s};
  endfunction

  // Drive one cycle, let the edge happen, then check the outputs 1 time unit later.
  task automatic cycle(input string tag, input logic r, input logic v,
                       input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    logic [9:0] e;
    rst_n    = r;
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    if (r && v) exp_q.push_back(ref_add(ta, tb, tc));
    @(posedge clk);
    #1;
    if (!r) begin
      held = 10'h000;
      check_eq({tag, ".vld"}, {31'd0, out_valid}, 32'd0);
      check_eq({tag, ".res"}, {22'd0, ovf, cout, sout}, 32'd0);
    end else if (v) begin
      check_eq({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
      if (exp_q.size() == 0) begin
        check_eq({tag, ".q_empty"}, 32'd1, 32'd0);
      end else begin
        e    = exp_q.pop_front();
        held = e;
        check_eq({tag, ".res"}, {22'd0, ovf, cout, sout}, {22'd0, e});
      end
    end else begin
      check_eq({tag, ".vld"}, {31'd0, out_valid}, 32'd0);
      check_eq({tag, ".hold"}, {22'd0, ovf, cout, sout}, {22'd0, held});
    end
  endtask

  logic [7:0] corner [5];

  initial begin
    total    = 0;
    bad      = 0;
    held     = 10'h000;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    cin      = 1'b0;
    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
    corner[3] = 8'h80; corner[4] = 8'hFF;

    // Reset for two edges with live-looking inputs, then an idle hold of zero.
    cycle("rst0", 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    cycle("rst1", 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    cycle("idle0", 1'b1, 1'b0, 8'h55, 8'hAA, 1'b1);

    // Directed cases.
    cycle("zero_c0", 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    cycle("zero_c1", 1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
    cycle("chain",   1'b1, 1'b1, 8'hFF, 8'h00, 1'b1);
    cycle("ovf_pos", 1'b1, 1'b1, 8'h7F, 8'h01, 1'b0);
    cycle("ovf_neg", 1'b1, 1'b1, 8'h80, 8'h80, 1'b0);
    // Pulse then idle: out_valid drops and the last result is held.
    cycle("pulse",   1'b1, 1'b1, 8'h3C, 8'h4B, 1'b1);
    cycle("hold1",   1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
    cycle("hold2",   1'b1, 1'b0, 8'h01, 8'h02, 1'b0);

    // Corner values on both operands and both carry-ins, back to back.
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int k = 0; k < 2; k++)
          cycle("corner", 1'b1, 1'b1, corner[i], corner[j], k[0]);

    // Reset mid-stream discards the pending add.
    cycle("pre_rst", 1'b1, 1'b1, 8'hC3, 8'h5A, 1'b0);
    cycle("mid_rst", 1'b0, 1'b1, 8'hFF, 8'h01, 1'b1);
    cycle("post_rst_idle", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Random back-to-back traffic with occasional idle cycles.
    for (int n = 0; n < 20000; n++) begin
      cycle("rand", 1'b1, ($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom),
            1'($urandom));
    end

    check_eq("q_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
